// File: rtl/cc_transi_sequencer.sv
// cc_transi_sequencer: drives a downstream selector through a fill/hold/clear
// transition pattern, stepping the pattern once every TICKCYCLES clocks.
module cc_transi_sequencer #(
    parameter int TRANSISEQ_TRANSIWIDTH = 8,
    parameter int TRANSISEQ_SELECTWIDTH = 1,
    parameter int TRANSISEQ_TICKCYCLES  = 4,
    parameter int TRANSISEQ_HOLDSTEPS   = 2
) (
    input  logic                             CC_TRANSISEQ_CLOCK_50,
    input  logic                             CC_TRANSISEQ_RESET_InHigh,
    input  logic                             CC_TRANSISEQ_start_In,
    output logic [TRANSISEQ_SELECTWIDTH-1:0] CC_TRANSISEQ_select_OutBUS,
    output logic [TRANSISEQ_TRANSIWIDTH-1:0] CC_TRANSISEQ_TRANSI_OutBUS,
    output logic                             CC_TRANSISEQ_busy_Out,
    output logic                             CC_TRANSISEQ_done_Out
);
    localparam int W  = TRANSISEQ_TRANSIWIDTH;
    localparam int TW = TRANSISEQ_TICKCYCLES > 1 ? $clog2(TRANSISEQ_TICKCYCLES) : 1;
    localparam int HW = TRANSISEQ_HOLDSTEPS > 1 ? $clog2(TRANSISEQ_HOLDSTEPS) : 1;

    typedef enum logic [2:0] {IDLE, FILL, HOLD, CLEAR, DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [W-1:0]    transi_q, transi_d;
    logic            busy_q, done_q;
    logic            run, step;

    assign run  = state_q inside {FILL, HOLD, CLEAR};
    assign step = tick_q == TW'(TRANSISEQ_TICKCYCLES - 1);

    always_comb begin
        state_d  = state_q;
        transi_d = transi_q;
        hold_d   = hold_q;
        tick_d   = run ? (step ? '0 : tick_q + 1'b1) : '0;
        case (state_q)
            IDLE: if (CC_TRANSISEQ_start_In) begin
                state_d  = FILL;
                transi_d = W'(1);
            end
            FILL: if (step) begin
                if (&transi_q) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end else transi_d = (transi_q << 1) | W'(1);
            end
            HOLD: if (step) begin
                if (hold_q == HW'(TRANSISEQ_HOLDSTEPS - 1)) begin
                    state_d  = CLEAR;
                    transi_d = transi_q << 1;
                end else hold_d = hold_q + 1'b1;
            end
            CLEAR: if (step) begin
                if (transi_q == '0) state_d = DONE;
                else transi_d = transi_q << 1;
            end
            DONE: begin
                state_d  = IDLE;
                transi_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flags are computed from the next state so every output leaves a flop.
    always_ff @(posedge CC_TRANSISEQ_CLOCK_50 or posedge CC_TRANSISEQ_RESET_InHigh) begin
        if (CC_TRANSISEQ_RESET_InHigh) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            hold_q   <= '0;
            transi_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            hold_q   <= hold_d;
            transi_q <= transi_d;
            busy_q   <= state_d inside {FILL, HOLD, CLEAR};
            done_q   <= state_d == DONE;
        end
    end

    assign CC_TRANSISEQ_select_OutBUS = TRANSISEQ_SELECTWIDTH'(busy_q);
    assign CC_TRANSISEQ_TRANSI_OutBUS = transi_q;
    assign CC_TRANSISEQ_busy_Out      = busy_q;
    assign CC_TRANSISEQ_done_Out      = done_q;
endmodule

// File: tb/tb_cc_transi_sequencer.sv
// tb_cc_transi_sequencer: scoreboard bench for two sequencer configurations
// (4 ticks/2 hold steps and 1 tick/1 hold step) sharing one stimulus stream.
module tb_cc_transi_sequencer;
    typedef struct packed {
        logic [7:0] tr;
        logic       sel;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel0, busy0, done0, sel1, busy1, done1;
    logic [7:0] tr0, tr1;

    exp_t q0[$];
    exp_t q1[$];
    bit   act[2];
    int   k[2];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cc_transi_sequencer dut0 (
        .CC_TRANSISEQ_CLOCK_50     (clk),
        .CC_TRANSISEQ_RESET_InHigh (rst),
        .CC_TRANSISEQ_start_In     (start),
        .CC_TRANSISEQ_select_OutBUS(sel0),
        .CC_TRANSISEQ_TRANSI_OutBUS(tr0),
        .CC_TRANSISEQ_busy_Out     (busy0),
        .CC_TRANSISEQ_done_Out     (done0)
    );

    cc_transi_sequencer #(.TRANSISEQ_TICKCYCLES(1), .TRANSISEQ_HOLDSTEPS(1)) dut1 (
        .CC_TRANSISEQ_CLOCK_50     (clk),
        .CC_TRANSISEQ_RESET_InHigh (rst),
        .CC_TRANSISEQ_start_In     (start),
        .CC_TRANSISEQ_select_OutBUS(sel1),
        .CC_TRANSISEQ_TRANSI_OutBUS(tr1),
        .CC_TRANSISEQ_busy_Out     (busy1),
        .CC_TRANSISEQ_done_Out     (done1)
    );

    function automatic int tcyc(input int i);
        return i == 0 ? 4 : 1;
    endfunction

    function automatic int hsteps(input int i);
        return i == 0 ? 2 : 1;
    endfunction

    function automatic int tlen(input int i);
        return tcyc(i) * (2 * 8 + hsteps(i));
    endfunction

    // Output expected k edges after the accepted start edge.
    function automatic exp_t expect_of(input int i);
        exp_t e;
        int   ph, v;
        e = '0;
        if (act[i] && k[i] == tlen(i)) e.done = 1'b1;
        else if (act[i]) begin
            ph = k[i] / tcyc(i);
            if (ph < 8) v = (1 << (ph + 1)) - 1;
            else if (ph < 8 + hsteps(i)) v = 255;
            else v = 255 << (ph - 8 - hsteps(i) + 1);
            e.tr   = v[7:0];
            e.sel  = 1'b1;
            e.busy = 1'b1;
        end
        return e;
    endfunction

    task automatic tick(input logic st, input logic ra);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                if (act[i]) begin
                    k[i]++;
                    if (k[i] == tlen(i) + 1) act[i] = 1'b0;
                end else if (start) begin
                    act[i] = 1'b1;
                    k[i]   = 0;
                end
            end
        end
        #1;
        rst = ra;
        if (ra) begin
            act[0] = 1'b0;
            act[1] = 1'b0;
        end
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
        start = st;
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            g = {tr0, sel0, busy0, done0};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL dut_t4h2 t=%0t got tr=%h sel=%b busy=%b done=%b want tr=%h sel=%b busy=%b done=%b",
                         $time, g.tr, g.sel, g.busy, g.done, e.tr, e.sel, e.busy, e.done);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            g = {tr1, sel1, busy1, done1};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL dut_t1h1 t=%0t got tr=%h sel=%b busy=%b done=%b want tr=%h sel=%b busy=%b done=%b",
                         $time, g.tr, g.sel, g.busy, g.done, e.tr, e.sel, e.busy, e.done);
            end
        end
    end

    initial begin
        act[0] = 1'b0;
        act[1] = 1'b0;
        k[0]   = 0;
        k[1]   = 0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        // single transition with ignored start pulses at edges 10 and 72
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 80; i++) tick(i == 10 || i == 72, 1'b0);
        // start held high: back-to-back transitions
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 147; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        // asynchronous reset mid-cycle after edge 35, restart right after release
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 120; i++) tick(i == 37, i == 36);
        for (int i = 0; i < 600; i++)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cc_transi_sequencer.md
CC_TRANSI_SEQUENCER -- requirements
Module: cc_transi_sequencer

Interface
REQ-001 The block SHALL use parameter TRANSISEQ_TRANSIWIDTH, default 8, as the width of the transition pattern bus; it matches the downstream selector's TRANSI input width.
REQ-002 The block SHALL use parameter TRANSISEQ_SELECTWIDTH, default 1, as the select bus width driven to the downstream selector.
REQ-003 The block SHALL use parameter TRANSISEQ_TICKCYCLES, default 4 (legal range >=1), as the number of clock cycles each pattern step is held.
REQ-004 The block SHALL use parameter TRANSISEQ_HOLDSTEPS, default 2 (legal range >=1), as the number of steps the all-ones pattern is held.
REQ-005 The block SHALL have CC_TRANSISEQ_CLOCK_50, an input, 1 bit, as the single system clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have CC_TRANSISEQ_RESET_InHigh, an input, 1 bit, as the asynchronous active-high reset.
REQ-007 The block SHALL have CC_TRANSISEQ_start_In, an input, 1 bit; it requests a transition and is sampled only in IDLE.
REQ-008 The block SHALL have CC_TRANSISEQ_select_OutBUS, an output, TRANSISEQ_SELECTWIDTH bits; 0 selects the idle (NADA) source and 1 selects the TRANSI pattern downstream.
REQ-009 The block SHALL have CC_TRANSISEQ_TRANSI_OutBUS, an output, TRANSISEQ_TRANSIWIDTH bits, carrying the current transition pattern.
REQ-010 The block SHALL have CC_TRANSISEQ_busy_Out, an output, 1 bit, high in FILL, HOLD and CLEAR.
REQ-011 The block SHALL have CC_TRANSISEQ_done_Out, an output, 1 bit, carrying a one-cycle pulse when a transition completes.
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-013 The FSM SHALL have exactly five states: IDLE, FILL, HOLD, CLEAR and DONE.
REQ-014 In IDLE, a rising clock edge with start=1 SHALL enter FILL with TRANSI=000...01, select=1, busy=1, and the tick counter cleared to 0; with start=0 the FSM SHALL stay in IDLE.
REQ-015 The tick counter SHALL count 0..TICKCYCLES-1; when it wraps from TICKCYCLES-1 to 0 a "step" event occurs; the counter runs in FILL, HOLD and CLEAR and is held at 0 otherwise.
REQ-016 On each step event in FILL, TRANSI SHALL shift left with a 1 inserted at the LSB (0x01, 0x03, 0x07 ... 0xFF for width 8).
REQ-017 On the first step event after TRANSI reaches all-ones in FILL, the FSM SHALL enter HOLD with TRANSI unchanged and the step counter cleared.
REQ-018 HOLD SHALL last exactly TRANSISEQ_HOLDSTEPS step events; on the last of them the FSM SHALL enter CLEAR with TRANSI = all-ones shifted left with a 0 inserted (0xFE).
REQ-019 On each step event in CLEAR, TRANSI SHALL shift left with a 0 inserted at the LSB; on the first step event after TRANSI reaches 0 the FSM SHALL enter DONE.
REQ-020 DONE SHALL last exactly one cycle with select=0, busy=0, done=1 and TRANSI=0, and SHALL then return to IDLE unconditionally.
REQ-021 In IDLE, the outputs SHALL be select=0, busy=0, done=0 and TRANSI=0.
REQ-022 start SHALL be ignored in FILL, HOLD, CLEAR and DONE: no restart, no queuing, and no timing change.
REQ-023 A start held high continuously SHALL produce back-to-back transitions, with IDLE occupying exactly one cycle between DONE and the next FILL.
REQ-024 Total transition length, from the start edge to the DONE edge, SHALL be TICKCYCLES*(2*W+HOLDSTEPS) cycles, where W is the pattern width.

Reset
REQ-025 Asserting RESET_InHigh SHALL immediately, without waiting for a clock edge, force IDLE, counters=0, select=0, TRANSI=0, busy=0 and done=0.
REQ-026 Reset asserted mid-transition SHALL abandon the transition without a done pulse; after release, the block SHALL wait for a new start.
REQ-027 A start sampled on the first clock edge after reset release SHALL be honoured normally.

Verification (W=8, TICKCYCLES=4, HOLDSTEPS=2, start edge = edge 0)
REQ-028 Full sequence SHALL be checked: edge0 TRANSI=0x01/select=1; edge4 0x03; edge28 0xFF; edge32 HOLD 0xFF; edge40 0xFE; edge68 0x00; edge72 done=1/select=0; edge73 IDLE.
REQ-029 Start pulses issued at edges 10 and 72 SHALL be checked to be ignored, with the timing identical to REQ-028.
REQ-030 Start held high continuously SHALL be checked: second FILL begins at edge 74 with TRANSI=0x01, done pulses at edges 72 and 146.
REQ-031 Reset asserted asynchronously mid-cycle during HOLD (edge 35) SHALL be checked: outputs go to 0 before the next edge, no done pulse occurs, and start after release gives TRANSI=0x01 on the next edge.
REQ-032 TICKCYCLES=1 and HOLDSTEPS=1 SHALL be checked: TRANSI changes every cycle, DONE occurs at edge 17, and busy is high for exactly 17 cycles.
